data_mem_initiator: RTL

Initiator side of the data-memory port. It accepts load/store requests from the CPU datapath over a valid/ready handshake and drives the word-addressed data memory's MemRead/MemWrite/address/data lines. It returns load data or store completion as a one-cycle response. It adds byte and halfword access, using lane extraction for loads and read-modify-write for stores, plus alignment and range checking.

---
 rtl/data_mem_pkg.sv | 34 +++
 rtl/data_mem_initiator_if.sv | 34 +++
 rtl/data_mem_initiator_mem_lane_align.sv | 49 ++++
 rtl/data_mem_initiator.sv | 133 +++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types for the data-memory initiator: access sizes, FSM states and the
// latched request record.
package data_mem_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_RSP  = 3'd4
   } state_e;

   typedef struct packed {
      logic        write;
      size_e       size;
      logic        unsigned_ext;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'(WORD_BYTES - 1);
   endfunction

endpackage

// File: rtl/data_mem_initiator_if.sv
// CPU request/response channel plus the word-addressed memory strobes.
// master = CPU datapath and memory, slave = the initiator.
interface data_mem_initiator_if;

   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [1:0]  ReqSize;
   logic        ReqUnsigned;
   logic [31:0] ReqAddress;
   logic [31:0] ReqWData;
   logic        RspValid;
   logic [31:0] RspData;
   logic        RspError;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] ReadAddress;
   logic [31:0] WriteAddress;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   modport master (
      output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddress, ReqWData, ReadData,
      input  ReqReady, RspValid, RspData, RspError,
             MemRead, MemWrite, ReadAddress, WriteAddress, WriteData
   );

   modport slave (
      input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddress, ReqWData, ReadData,
      output ReqReady, RspValid, RspData, RspError,
             MemRead, MemWrite, ReadAddress, WriteAddress, WriteData
   );

endinterface

// File: rtl/data_mem_initiator_mem_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module mem_lane_align
   import data_mem_pkg::*;
(
   input  size_e       i_size,
   input  logic [1:0]  i_lane,
   input  logic        i_unsigned,
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merge_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // NOTE: every output gets a default before the case, so no path leaves a latch.
   always_comb begin
      w_byte       = i_rdata[7:0];
      w_half       = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
      o_load_data  = i_rdata;
      o_merge_data = i_wdata;
      case (i_lane)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      case (i_size)
         SZ_BYTE: begin
            o_load_data  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            o_merge_data = i_rdata;
            case (i_lane)
               2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
               2'd2:    o_merge_data[23:16] = i_wdata[7:0];
               2'd3:    o_merge_data[31:24] = i_wdata[7:0];
               default: o_merge_data[7:0]   = i_wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            o_load_data  = {{16{~i_unsigned & w_half[15]}}, w_half};
            o_merge_data = i_lane[1] ? {i_wdata[15:0], i_rdata[15:0]}
                                     : {i_rdata[31:16], i_wdata[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_mem_initiator.sv
// Load/store initiator: validates a CPU request, runs read, read-modify-write or
// write against word-addressed memory, and returns a one-cycle response.
module data_mem_initiator
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 32
) (
   input  logic                Clock,
   input  logic                Reset,
   data_mem_initiator_if.slave bus
);

   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

   state_e      r_state, w_state_nxt;
   req_t        r_req, w_cur;
   logic        w_req_err;
   logic [31:0] w_load_data, w_merge_data;

   logic        r_mem_read, r_mem_write, r_rsp_valid, r_rsp_error;
   logic [31:0] r_read_addr, r_write_addr, r_write_data, r_rsp_data;
   logic        w_mem_read_nxt, w_mem_write_nxt, w_rsp_valid_nxt, w_rsp_error_nxt;
   logic [31:0] w_read_addr_nxt, w_write_addr_nxt, w_write_data_nxt, w_rsp_data_nxt;

   // In IDLE the live request is decoded so outputs can be registered at the accept edge.
   always_comb begin
      w_cur = r_req;
      if (r_state == ST_IDLE) begin
         w_cur.write        = bus.ReqWrite;
         w_cur.size         = size_e'(bus.ReqSize);
         w_cur.unsigned_ext = bus.ReqUnsigned;
         w_cur.addr         = bus.ReqAddress;
         w_cur.wdata        = bus.ReqWData;
      end
   end

   always_comb begin
      w_req_err = 1'b0;
      case (w_cur.size)
         SZ_HALF: w_req_err = w_cur.addr[0];
         SZ_WORD: w_req_err = |w_cur.addr[1:0];
         SZ_BAD:  w_req_err = 1'b1;
         default: ;
      endcase
      if ({1'b0, w_cur.addr} >= ADDR_LIMIT) w_req_err = 1'b1;
   end

   mem_lane_align u_align (
      .i_size       (w_cur.size),
      .i_lane       (w_cur.addr[1:0]),
      .i_unsigned   (w_cur.unsigned_ext),
      .i_rdata      (bus.ReadData),
      .i_wdata      (w_cur.wdata),
      .o_load_data  (w_load_data),
      .o_merge_data (w_merge_data)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (bus.ReqValid) begin
            if (w_req_err)                w_state_nxt = ST_RSP;
            else if (!w_cur.write)        w_state_nxt = ST_RD;
            else if (w_cur.size == SZ_WORD) w_state_nxt = ST_WR;
            else                          w_state_nxt = ST_RD;
         end
         ST_RD:   w_state_nxt = ST_CAP;
         ST_CAP:  w_state_nxt = w_cur.write ? ST_WR : ST_RSP;
         ST_WR:   w_state_nxt = ST_RSP;
         ST_RSP:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered with it.
   always_comb begin
      w_mem_read_nxt   = (w_state_nxt == ST_RD);
      w_mem_write_nxt  = (w_state_nxt == ST_WR);
      w_read_addr_nxt  = w_mem_read_nxt  ? word_align(w_cur.addr) : '0;
      w_write_addr_nxt = w_mem_write_nxt ? word_align(w_cur.addr) : '0;
      w_write_data_nxt = '0;
      if (w_mem_write_nxt)
         w_write_data_nxt = (r_state == ST_CAP) ? w_merge_data : w_cur.wdata;
      w_rsp_valid_nxt  = (w_state_nxt == ST_RSP);
      w_rsp_error_nxt  = r_rsp_error;
      w_rsp_data_nxt   = r_rsp_data;
      if (w_rsp_valid_nxt) begin
         w_rsp_error_nxt = (r_state == ST_IDLE);
         w_rsp_data_nxt  = (r_state == ST_CAP) ? w_load_data : '0;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state      <= ST_IDLE;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_read_addr  <= '0;
         r_write_addr <= '0;
         r_write_data <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_error  <= 1'b0;
         r_rsp_data   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_mem_read   <= w_mem_read_nxt;
         r_mem_write  <= w_mem_write_nxt;
         r_read_addr  <= w_read_addr_nxt;
         r_write_addr <= w_write_addr_nxt;
         r_write_data <= w_write_data_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_error  <= w_rsp_error_nxt;
         r_rsp_data   <= w_rsp_data_nxt;
      end
   end

   // NOTE: the payload is only consumed after an accept, so it needs no reset.
   always_ff @(posedge Clock) begin
      if (bus.ReqValid && r_state == ST_IDLE) r_req <= w_cur;
   end

   assign bus.ReqReady     = (r_state == ST_IDLE);
   assign bus.MemRead      = r_mem_read;
   assign bus.MemWrite     = r_mem_write;
   assign bus.ReadAddress  = r_read_addr;
   assign bus.WriteAddress = r_write_addr;
   assign bus.WriteData    = r_write_data;
   assign bus.RspValid     = r_rsp_valid;
   assign bus.RspData      = r_rsp_data;
   assign bus.RspError     = r_rsp_error;

endmodule
